y86_seq_controller: RTL and testbench

Phase sequencer for the sequential Y86-64 datapath. Owns the architectural PC register and the processor status code. Steps the fetch, decode, execute, memory, writeback and PC-update stages one phase per clock through one-hot enables, so each instruction takes 6 cycles. Supports free-run and single-step modes and stops on HLT, ADR and INS conditions. Replaces the free-running clock and combinational PC/stat loop in the sequential top level.

---
 rtl/y86_seq_controller.sv | 168 ++++++++++++++++
 tb/tb_y86_seq_controller.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_seq_controller.sv
// Phase sequencer for the sequential Y86-64 datapath.
// Owns the architectural PC and the status code. Walks one instruction through
// FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD, one phase per clock,
// and exposes the phase as registered one-hot enables. Supports free-run and
// single-step operation and stops for good on HLT, ADR or INS.
module y86_seq_controller #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             imem_error,
    input  logic             instr_valid,
    input  logic             halt_flag,
    input  logic             dmem_error,
    input  logic [63:0]      pc_next,
    output logic [63:0]      pc,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             writeback_en,
    output logic             pc_en,
    output logic [2:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    // Status codes as seen by the rest of the processor.
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // The six execution phases are encoded contiguously (1..6) so the
    // one-hot enable decode below is a simple offset compare.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXECUTE   = 4'd3,
        S_MEMORY    = 4'd4,
        S_WRITEBACK = 4'd5,
        S_PCUPD     = 4'd6,
        S_PAUSE     = 4'd7,
        S_STOPPED   = 4'd8
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [2:0]       stat_reg;
    logic [2:0]       stat_next;
    logic [63:0]      pc_reg;
    logic [5:0]       en_reg;
    logic [5:0]       en_next;
    logic             busy_reg;
    logic [CNT_W-1:0] cycle_count_reg;
    logic [CNT_W-1:0] instr_count_reg;
    logic [3:0]       state_next_code;
    logic             retire;

    // Next-state and status selection; errors in FETCH are prioritised ADR > INS > HLT.
    always_comb begin
        state_next = state_reg;
        stat_next  = stat_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_error) begin
                    stat_next  = STAT_ADR;
                    state_next = S_STOPPED;
                end else if (!instr_valid) begin
                    stat_next  = STAT_INS;
                    state_next = S_STOPPED;
                end else if (halt_flag) begin
                    stat_next  = STAT_HLT;
                    state_next = S_STOPPED;
                end else begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE:  state_next = S_EXECUTE;
            S_EXECUTE: state_next = S_MEMORY;
            S_MEMORY: begin
                // A data fault skips WRITEBACK and PCUPD so no architectural state changes.
                if (dmem_error) begin
                    stat_next  = STAT_ADR;
                    state_next = S_STOPPED;
                end else begin
                    state_next = S_WRITEBACK;
                end
            end
            S_WRITEBACK: state_next = S_PCUPD;
            S_PCUPD: begin
                // step_mode only matters here, at retirement.
                state_next = step_mode ? S_PAUSE : S_FETCH;
            end
            S_PAUSE: begin
                if (step_req || !step_mode) begin
                    state_next = S_FETCH;
                end
            end
            S_STOPPED: state_next = S_STOPPED;
            default:   state_next = S_IDLE;
        endcase
    end

    assign state_next_code = state_next;
    assign retire          = (state_reg == S_PCUPD);

    // One enable per phase, decoded from the next state and then registered
    // so the outputs are glitch-free and line up with the state register.
    for (genvar gi = 0; gi < 6; gi++) begin : g_phase_en
        assign en_next[gi] = (state_next_code == 4'(gi + 1));
    end

    // FSM state, registered outputs, PC and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            stat_reg        <= STAT_AOK;
            pc_reg          <= RESET_PC;
            en_reg          <= '0;
            busy_reg        <= 1'b0;
            cycle_count_reg <= '0;
            instr_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            stat_reg  <= stat_next;
            en_reg    <= en_next;
            busy_reg  <= |en_next;
            // busy_reg reflects the current state, so this counts cycles spent in a phase.
            if (busy_reg && (cycle_count_reg != CNT_MAX)) begin
                cycle_count_reg <= cycle_count_reg + CNT_ONE;
            end
            if (retire) begin
                pc_reg <= pc_next;
                if (instr_count_reg != CNT_MAX) begin
                    instr_count_reg <= instr_count_reg + CNT_ONE;
                end
            end
        end
    end

    assign pc           = pc_reg;
    assign stat         = stat_reg;
    assign busy         = busy_reg;
    assign cycle_count  = cycle_count_reg;
    assign instr_count  = instr_count_reg;
    assign fetch_en     = en_reg[0];
    assign decode_en    = en_reg[1];
    assign execute_en   = en_reg[2];
    assign memory_en    = en_reg[3];
    assign writeback_en = en_reg[4];
    assign pc_en        = en_reg[5];

endmodule

// File: tb/tb_y86_seq_controller.sv
// Testbench for y86_seq_controller: scenario table, hand-written step and
// reset sequences, counter saturation, and a randomized run, all cross-checked
// every cycle against a phase-counting reference model.
module tb_y86_seq_controller;

    localparam int          CW   = 8;
    localparam int          CMAX = 255;
    localparam logic [63:0] RPC  = 64'd0;

    logic          clk = 1'b0;
    logic          rst, start, step_mode, step_req;
    logic          imem_error, instr_valid, halt_flag, dmem_error;
    logic [63:0]   pc_next;
    logic [63:0]   pc;
    logic          fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en;
    logic [2:0]    stat;
    logic          busy;
    logic [CW-1:0] cycle_count, instr_count;

    always #5 clk = ~clk;

    y86_seq_controller #(.RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step_req(step_req),
        .imem_error(imem_error), .instr_valid(instr_valid), .halt_flag(halt_flag),
        .dmem_error(dmem_error), .pc_next(pc_next), .pc(pc),
        .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
        .memory_en(memory_en), .writeback_en(writeback_en), .pc_en(pc_en),
        .stat(stat), .busy(busy), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int pc_mode = 0;   // 1: pc_next follows the model PC plus 10

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: where we are inside the current instruction
    // (-1 waiting for start, 0..5 = phase index, 6 paused, 7 stopped).
    int          m_phase = -1;
    logic [63:0] m_pc    = RPC;
    logic [2:0]  m_stat  = 3'd1;
    int          m_ic    = 0;
    int          m_cc    = 0;

    always @(posedge clk) begin
        int ph, ic, cc;
        logic [63:0] p;
        logic [2:0] s;
        ph = m_phase; p = m_pc; s = m_stat; ic = m_ic; cc = m_cc;
        if (rst) begin
            ph = -1; p = RPC; s = 3'd1; ic = 0; cc = 0;
        end else begin
            if (ph >= 0 && ph <= 5) cc = (cc < CMAX) ? cc + 1 : CMAX;
            if (ph == -1) begin
                if (start) ph = 0;
            end else if (ph == 0) begin
                if (imem_error)        begin s = 3'd3; ph = 7; end
                else if (!instr_valid) begin s = 3'd4; ph = 7; end
                else if (halt_flag)    begin s = 3'd2; ph = 7; end
                else ph = 1;
            end else if (ph == 3 && dmem_error) begin
                s = 3'd3; ph = 7;
            end else if (ph >= 1 && ph <= 4) begin
                ph = ph + 1;
            end else if (ph == 5) begin
                p  = pc_next;
                ic = (ic < CMAX) ? ic + 1 : CMAX;
                ph = step_mode ? 6 : 0;
            end else if (ph == 6) begin
                if (step_req || !step_mode) ph = 0;
            end
        end
        m_phase <= ph; m_pc <= p; m_stat <= s; m_ic <= ic; m_cc <= cc;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [5:0] exp_en;
            for (int k = 0; k < 6; k++) exp_en[k] = (m_phase == k);
            check("model_enables", {pc_en, writeback_en, memory_en, execute_en, decode_en, fetch_en}, exp_en);
            check("model_busy", busy, (m_phase >= 0 && m_phase <= 5));
            check("model_pc", pc, m_pc);
            check("model_stat", stat, m_stat);
            check("model_instr_count", instr_count, m_ic);
            check("model_cycle_count", cycle_count, m_cc);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (pc_mode == 1) pc_next = m_pc + 64'd10;
        end
    endtask

    task automatic clear_inputs();
        start = 0; step_mode = 0; step_req = 0;
        imem_error = 0; instr_valid = 1; halt_flag = 0; dmem_error = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        cyc(2);
        rst = 0;
        if (pc_mode == 1) pc_next = m_pc + 64'd10;
    endtask

    task automatic pulse_start();
        start = 1;
        cyc();
        start = 0;
    endtask

    function automatic logic [5:0] all_en();
        return {pc_en, writeback_en, memory_en, execute_en, decode_en, fetch_en};
    endfunction

    typedef struct {
        int          n_instr;   // clean instructions before the fault
        int          fault;     // 0 none, 1 halt, 2 ins, 3 imem, 4 imem+ins, 5 dmem
        logic [2:0]  exp_stat;
        logic [63:0] exp_pc;
        int          exp_ic;
        int          exp_cc;
    } scen_t;

    scen_t scen [8];

    initial begin
        pc_next = 64'd0;
        clear_inputs();
        rst = 1;

        scen[0] = '{3, 0, 3'd1, 64'd30, 3, 18};
        scen[1] = '{1, 1, 3'd2, 64'd10, 1, 7};
        scen[2] = '{0, 2, 3'd4, 64'd0,  0, 1};
        scen[3] = '{2, 4, 3'd3, 64'd20, 2, 13};
        scen[4] = '{1, 3, 3'd3, 64'd10, 1, 7};
        scen[5] = '{2, 5, 3'd3, 64'd20, 2, 16};
        scen[6] = '{5, 0, 3'd1, 64'd50, 5, 30};
        scen[7] = '{0, 5, 3'd3, 64'd0,  0, 4};

        // Reset state.
        pc_mode = 1;
        do_reset();
        chk_en = 1;
        check("reset_pc", pc, 64'd0);
        check("reset_stat", stat, 3'd1);
        check("reset_busy", busy, 1'b0);
        check("reset_enables", all_en(), 6'd0);
        check("reset_instr_count", instr_count, 0);
        check("reset_cycle_count", cycle_count, 0);

        // Scenario table: run clean instructions, then inject one fault.
        for (int si = 0; si < 8; si++) begin
            do_reset();
            pulse_start();
            if (scen[si].fault == 0) begin
                cyc(6 * scen[si].n_instr);
                check($sformatf("scen%0d_busy", si), busy, 1'b1);
            end else begin
                for (int i = 0; i < 6 * scen[si].n_instr + 10; i++) begin
                    if (i == 6 * scen[si].n_instr) begin
                        case (scen[si].fault)
                            1: halt_flag = 1;
                            2: instr_valid = 0;
                            3: imem_error = 1;
                            4: begin imem_error = 1; instr_valid = 0; end
                            default: dmem_error = 1;
                        endcase
                    end
                    cyc();
                end
                // A stopped controller ignores start and step_req.
                start = 1; step_req = 1;
                cyc();
                start = 0; step_req = 0;
                cyc(3);
                check($sformatf("scen%0d_busy", si), busy, 1'b0);
                check($sformatf("scen%0d_enables", si), all_en(), 6'd0);
            end
            check($sformatf("scen%0d_stat", si), stat, scen[si].exp_stat);
            check($sformatf("scen%0d_pc", si), pc, scen[si].exp_pc);
            check($sformatf("scen%0d_instr_count", si), instr_count, scen[si].exp_ic);
            check($sformatf("scen%0d_cycle_count", si), cycle_count, scen[si].exp_cc);
            clear_inputs();
        end

        // Single-step: park in PAUSE, then release one instruction per step_req.
        do_reset();
        step_mode = 1;
        pulse_start();
        cyc(6);
        check("step_first_pc", pc, 64'd10);
        check("step_first_ic", instr_count, 1);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) start = 1;
            cyc();
            start = 0;
            check("step_pause_enables", all_en(), 6'd0);
        end
        check("step_pause_pc", pc, 64'd10);
        for (int k = 0; k < 3; k++) begin
            step_req = 1;
            cyc();
            step_req = 0;
            check("step_release_fetch", fetch_en, 1'b1);
            cyc(6);
            check("step_pc", pc, 64'd10 * (k + 2));
            check("step_ic", instr_count, k + 2);
            check("step_cc", cycle_count, 6 * (k + 2));
            check("step_paused", busy, 1'b0);
        end
        step_mode = 0;
        cyc();
        check("step_mode_clear_fetch", fetch_en, 1'b1);
        cyc(6);
        check("step_freerun_pc", pc, 64'd50);

        // Reset in the middle of EXECUTE abandons the instruction.
        pc_mode = 0;
        pc_next = 64'h40;
        do_reset();
        pulse_start();
        cyc(6);
        check("rst_mid_first_pc", pc, 64'h40);
        cyc(2);
        check("rst_mid_in_execute", execute_en, 1'b1);
        rst = 1;
        cyc();
        rst = 0;
        check("rst_mid_pc", pc, RPC);
        check("rst_mid_stat", stat, 3'd1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ic", instr_count, 0);
        check("rst_mid_cc", cycle_count, 0);

        // Counter saturation with the narrow counters.
        pc_mode = 1;
        do_reset();
        pulse_start();
        cyc(258);
        check("sat_cycle_count", cycle_count, CMAX);
        check("sat_ic_mid", instr_count, 43);
        cyc(1302);
        check("sat_instr_count", instr_count, CMAX);
        check("sat_cycle_hold", cycle_count, CMAX);

        // Randomized run against the reference model.
        pc_mode = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            start       = ($urandom_range(0, 3) == 0);
            step_req    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) step_mode = ~step_mode;
            imem_error  = ($urandom_range(0, 59) == 0);
            instr_valid = ($urandom_range(0, 59) != 0);
            halt_flag   = ($urandom_range(0, 79) == 0);
            dmem_error  = ($urandom_range(0, 59) == 0);
            pc_next     = {$urandom, $urandom};
            cyc();
        end

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
